disp_scan_ctrl: RTL and testbench

DISP_SCAN_CTRL -- requirements
Module: disp_scan_ctrl

---
 rtl/disp_pkg.sv | 12 +
 rtl/btn_debounce.sv | 30 +++
 rtl/disp_scan_ctrl.sv | 82 ++++++++
 tb/tb_disp_scan_ctrl.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/disp_pkg.sv
// disp_pkg: scan states, 7-segment code table and Gray-to-binary helper
package disp_pkg;
  typedef enum logic [1:0] {SHOW_U, GAP_U, SHOW_T, GAP_T} scan_state_e;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [9:0][6:0] SEG_CODES = {
    7'b0000100, 7'b0000000, 7'b0001111, 7'b0100000, 7'b0100100,
    7'b1001100, 7'b0000110, 7'b0010010, 7'b1001111, 7'b0000001
  };
  function automatic logic [3:0] gray2bin(input logic [3:0] g);
    return {g[3], ^g[3:2], ^g[3:1], ^g};
  endfunction
endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: 2-flop synchronizer, stability counter and one-cycle rise pulse
module btn_debounce #(
  parameter int DEB_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  output logic rise_o
);
  localparam int CW = $clog2(DEB_CYCLES + 1);
  logic [1:0] sync_q;
  logic level_q, rise_q, flip;
  logic [CW-1:0] cnt_q;
  assign flip = (sync_q[1] != level_q) && (cnt_q == CW'(DEB_CYCLES - 1));
  assign rise_o = rise_q;
  // level only follows the synchronized input after DEB_CYCLES equal samples
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q  <= '0;
      level_q <= 1'b0;
      cnt_q   <= '0;
      rise_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], btn_i};
      cnt_q   <= (sync_q[1] == level_q || flip) ? '0 : cnt_q + 1'b1;
      level_q <= flip ? ~level_q : level_q;
      rise_q  <= flip && !level_q;
    end
  end
endmodule

// File: rtl/disp_scan_ctrl.sv
// disp_scan_ctrl: two-digit multiplexed 7-segment driver for a Gray-coded value with freeze button
module disp_scan_ctrl
  import disp_pkg::*;
#(
  parameter int REFRESH_DIV = 50000,
  parameter int GAP_CYCLES  = 500,
  parameter int DEB_CYCLES  = 1000000,
  parameter int BLANK_LZ    = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] s,
  input  logic       load,
  input  logic       bot,
  output logic [6:0] seg,
  output logic       an0,
  output logic       an1,
  output logic       frozen
);
  localparam int CW = $clog2((REFRESH_DIV > GAP_CYCLES ? REFRESH_DIV : GAP_CYCLES) + 1);
  localparam logic [CW-1:0] SHOW_LD = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] GAP_LD  = CW'(GAP_CYCLES - 1);
  scan_state_e state_q, state_d, nxt;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0] gray_q, bin, units_q;
  logic tens_q, frozen_q, rise, an0_q, an1_q, an0_d, an1_d;
  logic [6:0] seg_q, seg_d;
  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
    .clk(clk),
    .rst(rst),
    .btn_i(bot),
    .rise_o(rise)
  );
  assign bin = gray2bin(gray_q);
  assign seg = seg_q;
  assign an0 = an0_q;
  assign an1 = an1_q;
  assign frozen = frozen_q;
  // capture and digit split; the old frozen value gates load so a same-edge toggle still lets it in
  always_ff @(posedge clk) begin
    if (rst) begin
      gray_q   <= '0;
      frozen_q <= 1'b0;
      units_q  <= '0;
      tens_q   <= 1'b0;
    end else begin
      gray_q   <= (load && !frozen_q) ? s : gray_q;
      frozen_q <= rise ? ~frozen_q : frozen_q;
      units_q  <= (bin >= 4'd10) ? bin - 4'd10 : bin;
      tens_q   <= bin >= 4'd10;
    end
  end
  // next slot, shared countdown reload and the output pattern for the current slot
  always_comb begin
    nxt = state_q == SHOW_U ? (GAP_CYCLES == 0 ? SHOW_T : GAP_U) :
          state_q == GAP_U  ? SHOW_T :
          state_q == SHOW_T ? (GAP_CYCLES == 0 ? SHOW_U : GAP_T) : SHOW_U;
    state_d = cnt_q == '0 ? nxt : state_q;
    cnt_d = cnt_q != '0 ? cnt_q - 1'b1 : (nxt == SHOW_U || nxt == SHOW_T) ? SHOW_LD : GAP_LD;
    seg_d = state_q == SHOW_U ? SEG_CODES[units_q] :
            state_q == SHOW_T ? (tens_q ? SEG_CODES[1] : (BLANK_LZ != 0 ? SEG_BLANK : SEG_CODES[0])) :
            SEG_BLANK;
    an0_d = state_q != SHOW_U;
    an1_d = state_q != SHOW_T;
  end
  // scan FSM with registered segment and anode outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SHOW_U;
      cnt_q   <= SHOW_LD;
      seg_q   <= SEG_BLANK;
      an0_q   <= 1'b1;
      an1_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      seg_q   <= seg_d;
      an0_q   <= an0_d;
      an1_q   <= an1_d;
    end
  end
endmodule

// File: tb/tb_disp_scan_ctrl.sv
// tb_disp_scan_ctrl: directed checks of scan timing, digit codes, freeze and reset
module tb_disp_scan_ctrl;
  logic clk = 1'b0, rst, load, bot, an0, an1, frozen;
  logic [3:0] s;
  logic [6:0] seg;
  int tests = 0, failed = 0, both_low = 0, n;
  localparam logic [6:0] BL = 7'b1111111;

  disp_scan_ctrl #(.REFRESH_DIV(4), .GAP_CYCLES(1), .DEB_CYCLES(3), .BLANK_LZ(1)) dut (
    .clk(clk), .rst(rst), .s(s), .load(load), .bot(bot),
    .seg(seg), .an0(an0), .an1(an1), .frozen(frozen)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (!rst && !an0 && !an1) both_low++;

  function automatic logic [6:0] code(input int d);
    case (d)
      0: return 7'b0000001;
      1: return 7'b1001111;
      2: return 7'b0010010;
      3: return 7'b0000110;
      4: return 7'b1001100;
      5: return 7'b0100100;
      6: return 7'b0100000;
      7: return 7'b0001111;
      8: return 7'b0000000;
      default: return 7'b0000100;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_for(input logic a0, input logic a1, input string tag);
    int k = 0;
    while (!(an0 == a0 && an1 == a1) && k < 40) begin
      tick();
      k++;
    end
    check(tag, {an0, an1}, {a0, a1});
  endtask

  task automatic run_len(input logic a0, input logic a1, output int len);
    len = 0;
    while (an0 == a0 && an1 == a1 && len < 50) begin
      len++;
      tick();
    end
  endtask

  task automatic load_val(input logic [3:0] v);
    s = v;
    load = 1'b1;
    tick();
    load = 1'b0;
    repeat (3) tick();
  endtask

  task automatic show(input logic [6:0] eu, input logic [6:0] et, input string tag);
    wait_for(1'b0, 1'b1, {tag, "_wu"});
    check({tag, "_u"}, seg, eu);
    wait_for(1'b1, 1'b0, {tag, "_wt"});
    check({tag, "_t"}, seg, et);
  endtask

  task automatic press(input int len);
    bot = 1'b1;
    repeat (len) tick();
    bot = 1'b0;
    repeat (8) tick();
  endtask

  initial begin
    rst = 1'b1; s = 4'b0; load = 1'b0; bot = 1'b0;
    tick(); tick();
    check("rst_seg", seg, BL);
    check("rst_an", {an0, an1}, 2'b11);
    check("rst_frz", frozen, 1'b0);
    rst = 1'b0;
    tick();
    check("first_u_seg", seg, code(0));
    check("first_u_an", {an0, an1}, 2'b01);

    load_val(4'b1101);
    show(code(9), BL, "v9");

    wait_for(1'b1, 1'b0, "al_t");
    wait_for(1'b0, 1'b1, "al_u");
    s = 4'b1000; load = 1'b1;
    tick();
    load = 1'b0;
    tick();
    check("lat_old", seg, code(9));
    tick();
    check("lat_new", seg, code(5));
    wait_for(1'b1, 1'b0, "seq_a");
    wait_for(1'b0, 1'b1, "seq_b");
    run_len(1'b0, 1'b1, n); check("len_show_u", n, 4);
    run_len(1'b1, 1'b1, n); check("len_gap_u", n, 1);
    check("v15_t", seg, code(1));
    run_len(1'b1, 1'b0, n); check("len_show_t", n, 4);
    run_len(1'b1, 1'b1, n); check("len_gap_t", n, 1);

    press(3);
    check("frz_on", frozen, 1'b1);
    load_val(4'b0000);
    show(code(5), code(1), "frz_hold");
    press(2);
    check("glitch", frozen, 1'b1);
    press(3);
    check("frz_off", frozen, 1'b0);
    load_val(4'b1111);
    show(code(0), code(1), "v10");

    bot = 1'b1;
    repeat (3) tick();
    bot = 1'b0;
    repeat (2) tick();
    s = 4'b0100; load = 1'b1;
    tick();
    load = 1'b0;
    check("same_edge_frz", frozen, 1'b1);
    repeat (3) tick();
    show(code(7), BL, "same_edge");

    wait_for(1'b1, 1'b0, "mid_t");
    rst = 1'b1;
    tick();
    check("mrst_seg", seg, BL);
    check("mrst_an", {an0, an1}, 2'b11);
    check("mrst_frz", frozen, 1'b0);
    rst = 1'b0;
    tick();
    check("mrst_u_seg", seg, code(0));
    check("mrst_u_an", {an0, an1}, 2'b01);
    wait_for(1'b1, 1'b0, "mrst_wt");
    check("mrst_t", seg, BL);

    for (int i = 0; i < 16; i++) begin
      load_val(4'(i ^ (i >> 1)));
      show(code(i % 10), i >= 10 ? code(1) : BL, $sformatf("sw%0d", i));
    end

    check("an_excl", both_low, 0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
